// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the round-robin multiplier arbiter.
// Optional MULT_ARB_ZERO_BYPASS_EN build skips MUL for zero operands.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } mult_arb_state_e;

    localparam int N_DEF    = 8;
    localparam int NREQ_DEF = 4;

    function automatic int id_w(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Request/response bundle between requesters and the multiplier arbiter.
// Requester operands are packed N bits per requester, index 0 lowest.
interface mult_arbiter_if
    import mult_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
);
    localparam int ID_W = id_w(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*N-1:0]    rsp_product;
    logic [ID_W-1:0]   rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_product, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_product, rsp_id
    );

endinterface

// File: rtl/m_array_mult.sv
// Combinational unsigned array multiplier shared by the arbiter.
// Full 2N-bit product, built from shifted partial products.
module M_ARRAY_MULT #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [2*N-1:0] a_ext;

    assign a_ext = {{N{1'b0}}, a_i};

    always_comb begin
        p_o = '0;
        for (int i = 0; i < N; i++) begin
            if (b_i[i]) p_o = p_o + (a_ext << i);
        end
    end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around; returns one-hot grant plus encoded index.
module mult_rr_arbiter
    import mult_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [ID_W-1:0] idx_o,
    output logic            vld_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one M_ARRAY_MULT among NREQ requesters.
// Define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests a cycle early.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mult_arbiter_if.slave bus,
    output logic         busy
);

    localparam int ID_W = id_w(NREQ);

    mult_arb_state_e state_q, state_d;

    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gidx;
    logic            gvld;
    logic [N-1:0]    a_sel, b_sel;
    logic [N-1:0]    a_q, b_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [2*N-1:0]  prod_q, mul_p;
    logic            accept, hs, zero;

    mult_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .vld_o (gvld)
    );

    M_ARRAY_MULT #(.N(N)) u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (mul_p)
    );

    assign a_sel  = bus.req_a[N*int'(gidx) +: N];
    assign b_sel  = bus.req_b[N*int'(gidx) +: N];
    assign accept = (state_q == IDLE) && gvld;
    assign hs     = (state_q == RESP) && bus.rsp_ready;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign zero = (a_sel == '0) || (b_sel == '0);
`else
    assign zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gvld) state_d = zero ? RESP : MUL;
            MUL:     state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next search starts just past the requester that was served.
    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            prod_q <= '0;
        end else begin
            if (accept) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= gidx;
            end
            if (state_q == MUL) prod_q <= mul_p;
            if (accept && zero) prod_q <= '0;
        end
    end

    always_comb begin
        bus.req_ready   = (state_q == IDLE) ? gnt : '0;
        bus.rsp_valid   = (state_q == RESP);
        bus.rsp_product = prod_q;
        bus.rsp_id      = id_q;
        busy            = (state_q != IDLE);
    end

endmodule
